// File: rtl/mem_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter_if
// Brief    : Cache-side, memory-side and routed-response signals of the
//            shared main-memory port arbiter.
// Revision : 1.0
// ============================================================================
interface mem_bus_arbiter_if;
   logic [1:0]  icache2mem_command;
   logic [63:0] icache2mem_addr;
   logic [1:0]  dcache2mem_command;
   logic [63:0] dcache2mem_addr;
   logic [63:0] dcache2mem_data;
   logic [3:0]  mem2proc_response;
   logic [63:0] mem2proc_data;
   logic [3:0]  mem2proc_tag;
   logic [1:0]  proc2mem_command;
   logic [63:0] proc2mem_addr;
   logic [63:0] proc2mem_data;
   logic [3:0]  mem2icache_response;
   logic [3:0]  mem2icache_tag;
   logic [63:0] mem2icache_data;
   logic [3:0]  mem2dcache_response;
   logic [3:0]  mem2dcache_tag;
   logic [63:0] mem2dcache_data;
   logic        arb_error;

   // Caches and memory drive the requests and responses.
   modport master (
      output icache2mem_command, icache2mem_addr,
      output dcache2mem_command, dcache2mem_addr, dcache2mem_data,
      output mem2proc_response, mem2proc_data, mem2proc_tag,
      input  proc2mem_command, proc2mem_addr, proc2mem_data,
      input  mem2icache_response, mem2icache_tag, mem2icache_data,
      input  mem2dcache_response, mem2dcache_tag, mem2dcache_data,
      input  arb_error
   );

   // The arbiter consumes them and drives the routed results.
   modport slave (
      input  icache2mem_command, icache2mem_addr,
      input  dcache2mem_command, dcache2mem_addr, dcache2mem_data,
      input  mem2proc_response, mem2proc_data, mem2proc_tag,
      output proc2mem_command, proc2mem_addr, proc2mem_data,
      output mem2icache_response, mem2icache_tag, mem2icache_data,
      output mem2dcache_response, mem2dcache_tag, mem2dcache_data,
      output arb_error
   );
endinterface
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter
// Brief    : icache/dcache arbiter for the single memory port, with a
//            tag-ownership table that steers returning load data back.
// Revision : 1.0
// ============================================================================
module mem_bus_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  wire logic         clock,
   input  wire logic         reset,
   mem_bus_arbiter_if.slave  bus
);

   localparam logic [1:0] c_bus_none     = 2'd0;
   localparam logic [1:0] c_bus_load     = 2'd1;
   localparam logic [2:0] c_starve_limit = 3'(STARVE_LIMIT);

   logic [15:0] r_valid;
   logic [15:0] r_owner;        // 1 = dcache owns the tag
   logic [2:0]  r_starve_cnt;
   logic        r_arb_error;

   logic        w_icache_req;
   logic        w_dcache_req;
   logic        w_grant_icache;
   logic        w_grant_dcache;
   logic        w_alloc;
   logic [3:0]  w_alloc_tag;
   logic        w_alloc_conflict;
   logic [3:0]  w_ret_tag;
   logic        w_ret_hit;
   logic        w_ret_unowned;
   logic        w_ret_owner_d;
   logic [15:0] w_valid_next;

   assign w_icache_req   = bus.icache2mem_command != c_bus_none;
   assign w_dcache_req   = bus.dcache2mem_command != c_bus_none;
   assign w_grant_icache = !reset && w_icache_req &&
                           (!w_dcache_req || r_starve_cnt == c_starve_limit);
   assign w_grant_dcache = !reset && w_dcache_req && !w_grant_icache;

   always_comb begin
      bus.proc2mem_command = c_bus_none;
      bus.proc2mem_addr    = 64'd0;
      bus.proc2mem_data    = 64'd0;
      if (w_grant_dcache) begin
         bus.proc2mem_command = bus.dcache2mem_command;
         bus.proc2mem_addr    = bus.dcache2mem_addr;
         bus.proc2mem_data    = bus.dcache2mem_data;
      end else if (w_grant_icache) begin
         bus.proc2mem_command = bus.icache2mem_command;
         bus.proc2mem_addr    = bus.icache2mem_addr;
      end
   end

   assign bus.mem2icache_response = w_grant_icache ? bus.mem2proc_response : 4'd0;
   assign bus.mem2dcache_response = w_grant_dcache ? bus.mem2proc_response : 4'd0;

   // Returns are steered by the owner recorded before this edge's update.
   assign w_ret_tag     = bus.mem2proc_tag;
   assign w_ret_hit     = !reset && (w_ret_tag != 4'd0) && r_valid[w_ret_tag];
   assign w_ret_unowned = !reset && (w_ret_tag != 4'd0) && !r_valid[w_ret_tag];
   assign w_ret_owner_d = r_owner[w_ret_tag];

   assign bus.mem2icache_tag  = (w_ret_hit && !w_ret_owner_d) ? w_ret_tag : 4'd0;
   assign bus.mem2icache_data = (w_ret_hit && !w_ret_owner_d) ? bus.mem2proc_data : 64'd0;
   assign bus.mem2dcache_tag  = (w_ret_hit &&  w_ret_owner_d) ? w_ret_tag : 4'd0;
   assign bus.mem2dcache_data = (w_ret_hit &&  w_ret_owner_d) ? bus.mem2proc_data : 64'd0;
   assign bus.arb_error       = r_arb_error;

   assign w_alloc     = (bus.mem2proc_response != 4'd0) &&
                        ((w_grant_icache && bus.icache2mem_command == c_bus_load) ||
                         (w_grant_dcache && bus.dcache2mem_command == c_bus_load));
   assign w_alloc_tag = bus.mem2proc_response;
   // A tag freed by a return in the same cycle may be reissued without error.
   assign w_alloc_conflict = w_alloc && r_valid[w_alloc_tag] &&
                             !(w_ret_hit && (w_ret_tag == w_alloc_tag));

   always_comb begin
      w_valid_next = r_valid;
      if (w_ret_hit) begin
         w_valid_next[w_ret_tag] = 1'b0;
      end
      if (w_alloc) begin
         w_valid_next[w_alloc_tag] = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_valid      <= '0;
         r_owner      <= '0;
         r_starve_cnt <= '0;
         r_arb_error  <= 1'b0;
      end else begin
         if (w_icache_req && !w_grant_icache) begin
            if (r_starve_cnt != c_starve_limit) begin
               r_starve_cnt <= r_starve_cnt + 3'd1;
            end
         end else begin
            r_starve_cnt <= '0;
         end
         if (w_ret_unowned || w_alloc_conflict) begin
            r_arb_error <= 1'b1;
         end
         r_valid <= w_valid_next;
         if (w_alloc) begin
            r_owner[w_alloc_tag] <= w_grant_dcache;
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares the single main-memory port between the instruction cache and the data cache. It grants at most one bus command per cycle and forwards the memory's same-cycle response to the winning requester only. A 16-entry tag-ownership table routes each returning tag and its data back to the cache that issued the load. It sits between the icache/dcache memory ports and main memory.

## Interface
- STARVE_LIMIT, 4: consecutive lost icache cycles before icache is forced to win.
- clock  in  1  system clock.
- reset  in  1  reset, synchronous, active-high.
- icache2mem_command  in  2  BUS_NONE/BUS_LOAD from icache.
- icache2mem_addr  in  64  icache request address.
- dcache2mem_command  in  2  BUS_NONE/BUS_LOAD/BUS_STORE from dcache.
- dcache2mem_addr  in  64  dcache request address.
- dcache2mem_data  in  64  dcache store data.
- mem2proc_response  in  4  tag accepted this cycle; 0 = rejected.
- mem2proc_data  in  64  returning load data.
- mem2proc_tag  in  4  returning load tag; 0 = none.
- proc2mem_command, proc2mem_addr, proc2mem_data  out  2/64/64  granted request to memory.
- mem2icache_response, mem2icache_tag  out  4/4  icache-routed response and tag.
- mem2icache_data  out  64  icache-routed data.
- mem2dcache_response, mem2dcache_tag  out  4/4  dcache-routed response and tag.
- mem2dcache_data  out  64  dcache-routed data.
- arb_error  out  1  sticky: a tag returned that has no owner.

## Operation
- Command encoding follows sys_defs: BUS_NONE=0, BUS_LOAD=1, BUS_STORE=2. Any non-NONE command is a request.
- Grant is combinational:
  - dcache wins when both request.
  - Exception: icache wins when starve_cnt == STARVE_LIMIT.
  - A lone requester always wins.
- Driving the bus:
  - proc2mem_* carries the granted request. proc2mem_data is dcache2mem_data on a dcache grant, else 0.
  - With no grant: command BUS_NONE, addr 0, data 0.
- Response routing: mem2proc_response goes to the granted client's *_response. The loser sees 0 and must hold its request and retry.
- starve_cnt (3 bits):
  - Increments when icache requests and is not granted; saturates at STARVE_LIMIT.
  - Clears when icache is granted or not requesting.
- Ownership table: valid[15:1] plus owner[15:1] (1 = dcache).
  - A granted BUS_LOAD with response != 0 sets valid[resp] and writes its owner at the clock edge.
  - A BUS_STORE never allocates.
- Return routing (combinational from table state):
  - If mem2proc_tag != 0 and valid[tag], the owner's *_tag/*_data = mem2proc_tag/mem2proc_data. The non-owner sees tag 0, data 0.
  - valid[tag] clears at the edge.
- Unowned return: mem2proc_tag != 0 with valid[tag]=0 is dropped. Both outputs stay 0, and arb_error sets at the edge.
- Same-cycle return and reallocation of the same tag: the clear applies first, then the set. The entry ends valid with the new owner, and the return routes using the old owner.
- Allocating a tag that is already valid overwrites the entry and sets arb_error.

## Timing
- Grant and response paths have zero latency, because memory answers in the command cycle. Return routing also has zero latency.
- Table, starve_cnt and arb_error update on the posedge.
- Reset effects, applied at the edge:
  - Table cleared, starve_cnt=0, arb_error=0.
  - While reset is high, proc2mem_command=BUS_NONE and all client outputs are 0.
- Reset mid-operation discards outstanding ownership. Later returns of pre-reset tags are dropped and set arb_error.
- Worst-case icache wait under continuous dcache traffic: STARVE_LIMIT+1 cycles.

## Test plan
- Lone icache load, memory responds 3 -> proc2mem_command=1 and mem2icache_response=3 in the same cycle. Two cycles later, tag 3 with data 0xDEAD -> mem2icache_tag=3, data=0xDEAD; dcache tag/data are 0.
- Both request every cycle, memory always accepts -> dcache granted for cycles 0–3, icache granted in cycle 4, starve_cnt returns to 0, and the pattern repeats.
- dcache store with response 5, then tag 5 returned -> no allocation, tag dropped, arb_error=1 from the next cycle.
- icache load takes tag 7; in the cycle tag 7 returns, a dcache load is granted tag 7 -> data goes to icache, entry 7 is valid/dcache afterwards, arb_error stays 0.
- Memory rejects a dcache load (response 0) -> mem2dcache_response=0 and no allocation; the retry in the next cycle with response 2 allocates tag 2.
- Reset asserted with tags 1 and 2 outstanding, then tag 1 returns -> both client tags are 0 and arb_error=1.
